// File: rtl/debounce_pkg.sv
// Shared types and default constants for the input debouncer.
`timescale 1ns/1ps
package debounce_pkg;

  // Qualification FSM: two stable levels, each with a counting state toward the other
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    CNT_HIGH  = 2'b01,
    IDLE_HIGH = 2'b10,
    CNT_LOW   = 2'b11
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 16;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit; reusable for any async input.
`timescale 1ns/1ps
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic d_sync
);

  logic [SYNC_STAGES-1:0] r_ff;

  // Shift the raw input through the chain; oldest sample is the synchronised output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ff <= '0;
    end else begin
      r_ff <= {r_ff[SYNC_STAGES-2:0], d_async};
    end
  end

  assign d_sync = r_ff[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input into a clean level plus rise/fall strobes.
`timescale 1ns/1ps
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic enable,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject illegal parameterisations at elaboration
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES must be in 2..4");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("input_debouncer: STABLE_CYCLES must be at least 2");
  end

  logic             w_s;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;
  logic             r_busy, w_busy_nxt;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_async(din),
    .d_sync (w_s)
  );

  // State, counter and all outputs are registered together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic; enable=0 freezes state/count/level and suppresses strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;

    if (enable) begin
      case (r_state)
        IDLE_LOW: begin
          if (w_s) begin
            w_state_nxt = CNT_HIGH;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        CNT_HIGH: begin
          if (!w_s) begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE_HIGH;
            w_cnt_nxt   = '0;
            w_dout_nxt  = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!w_s) begin
            w_state_nxt = CNT_LOW;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        CNT_LOW: begin
          if (w_s) begin
            w_state_nxt = IDLE_HIGH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = '0;
            w_dout_nxt  = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == CNT_HIGH) || (w_state_nxt == CNT_LOW);
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with a strobe scoreboard.
`timescale 1ns/1ps
module tb_input_debouncer;

  logic clk = 1'b0;
  logic reset, din, enable;
  logic dout, rise, fall, busy;

  input_debouncer dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .enable(enable),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: value after the Nth rising edge is N
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_rise;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_cmp    = 0;
  int  n_err    = 0;
  int  both_cnt = 0;

  // Capture every strobe cycle just after the edge that produced it
  always begin
    ev_t e;
    @(posedge clk);
    #1;
    if (rise) begin
      e.is_rise = 1'b1;
      e.cyc     = cyc;
      obs_q.push_back(e);
    end
    if (fall) begin
      e.is_rise = 1'b0;
      e.cyc     = cyc;
      obs_q.push_back(e);
    end
    if (rise && fall) both_cnt++;
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input bit is_rise, input int at_cyc);
    ev_t e;
    e.is_rise = is_rise;
    e.cyc     = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for the next strobe and score it against the oldest expectation
  task automatic wait_event(input string tag);
    ev_t o, e;
    int  k = 0;
    while (obs_q.size() == 0 && k < 40) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (obs_q.size() == 0) begin
      check({tag, "_timeout"}, obs_q.size(), 1);
    end else begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_kind"}, int'(o.is_rise), int'(e.is_rise));
        check({tag, "_cycle"}, o.cyc, e.cyc);
      end
    end
  endtask

  initial begin
    int base;
    int last_rise;
    int saw_busy;
    int dout_hi;

    // Reset hold with din=1
    reset  = 1'b0;
    din    = 1'b1;
    enable = 1'b1;
    tick(1);
    check("rst_dout", int'(dout), 0);
    check("rst_rise", int'(rise), 0);
    check("rst_fall", int'(fall), 0);
    check("rst_busy", int'(busy), 0);
    tick(1);
    check("rst_dout2", int'(dout), 0);
    check("rst_busy2", int'(busy), 0);
    reset = 1'b1;
    push_exp(1'b1, cyc + 18);
    wait_event("rst_release_rise");
    tick(1);
    check("rst_dout_hi", int'(dout), 1);
    tick(1);
    check("rst_rise_one_cycle", int'(rise), 0);
    check("rst_dout_held", int'(dout), 1);

    // Clean release then press/release
    din = 1'b0;
    push_exp(1'b0, cyc + 18);
    wait_event("clean_pre_fall");
    tick(1);
    check("clean_pre_dout", int'(dout), 0);
    din = 1'b1;
    push_exp(1'b1, cyc + 18);
    wait_event("clean_rise");
    tick(1);
    check("clean_dout_hi", int'(dout), 1);
    tick(12);
    din = 1'b0;
    push_exp(1'b0, cyc + 18);
    wait_event("clean_fall");
    tick(1);
    check("clean_dout_lo", int'(dout), 0);
    tick(20);
    check("clean_no_extra", obs_q.size(), 0);

    // Glitch: 5 cycles high, then low
    saw_busy = 0;
    dout_hi  = 0;
    din = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (busy) saw_busy = 1;
      if (dout) dout_hi = 1;
    end
    din = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (busy) saw_busy = 1;
      if (dout) dout_hi = 1;
    end
    check("glitch_busy_seen", saw_busy, 1);
    check("glitch_dout_low", dout_hi, 0);
    check("glitch_busy_end", int'(busy), 0);
    check("glitch_no_strobe", obs_q.size(), 0);

    // Bounce: toggle every 3 cycles, finally held high
    last_rise = 0;
    for (int i = 0; i < 7; i++) begin
      din = ((i % 2) == 0);
      if (i == 6) begin
        last_rise = cyc;
        push_exp(1'b1, last_rise + 18);
      end
      tick(3);
    end
    wait_event("bounce_rise");
    tick(1);
    check("bounce_dout_hi", int'(dout), 1);
    tick(20);
    check("bounce_single_rise", obs_q.size(), 0);
    din = 1'b0;
    push_exp(1'b0, cyc + 18);
    wait_event("bounce_fall");
    tick(5);

    // Enable freeze at cnt=8
    din  = 1'b1;
    base = cyc;
    tick(10);
    enable = 1'b0;
    tick(10);
    check("freeze_busy", int'(busy), 1);
    check("freeze_dout", int'(dout), 0);
    check("freeze_no_strobe", obs_q.size(), 0);
    check("freeze_len", cyc - base, 20);
    enable = 1'b1;
    push_exp(1'b1, cyc + 8);
    wait_event("freeze_rise");
    tick(1);
    check("freeze_dout_hi", int'(dout), 1);
    din = 1'b0;
    push_exp(1'b0, cyc + 18);
    wait_event("freeze_fall");
    tick(5);

    // Reset mid-count at cnt=10
    din = 1'b1;
    tick(12);
    check("midrst_busy_pre", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("midrst_busy_async", int'(busy), 0);
    check("midrst_dout_async", int'(dout), 0);
    tick(1);
    reset = 1'b1;
    push_exp(1'b1, cyc + 18);
    wait_event("midrst_rise");
    tick(1);
    check("midrst_dout_hi", int'(dout), 1);

    // Final scoreboard drain
    tick(5);
    check("end_obs_empty", obs_q.size(), 0);
    check("end_exp_empty", exp_q.size(), 0);
    check("end_never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
